asr_tap: RTL and testbench

- Parametrised addressable shift register: the next generation of the 8-stage fixed-depth asr8.
- Configurable width and depth.
- Two independent combinational read taps, each with a valid flag.
- Fill-level tracking, a synchronous flush, and a rotate (circular) mode.
- Used as a variable-delay line and tap-selectable history buffer in the datapath.

---
 rtl/asr_pkg.sv | 14 +
 rtl/asr_fill_ctr.sv | 41 ++++
 rtl/asr_tap.sv | 82 ++++++++
 tb/tb_asr_tap.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/asr_pkg.sv
// Shared constants and helpers for the addressable shift register.
package asr_pkg;

    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_ROT   = 1'b1;

    // Tap address width; a DEPTH of 1 would otherwise give a zero-width address.
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/asr_fill_ctr.sv
// Saturating count of valid stages; flush restarts the count, keeping a same-cycle shift.
module asr_fill_ctr
    import asr_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int FW = clog2_min1(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          flush,
    input  logic          inc,
    output logic [FW-1:0] fill,
    output logic          full
);

    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = inc ? FW'(1) : '0;
        end else if (inc && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;
    assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/asr_tap.sv
// Parametrised addressable shift register with shift/rotate modes and two zero-latency read taps.
module asr_tap
    import asr_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    localparam int AW   = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic          rot,
    input  logic          flush,
    input  logic [N-1:0]  d,
    input  logic [AW-1:0] add_a,
    input  logic [AW-1:0] add_b,
    output logic [N-1:0]  q_a,
    output logic [N-1:0]  q_b,
    output logic          vld_a,
    output logic          vld_b,
    output logic [AW:0]   fill,
    output logic          full
);

    logic [N-1:0] stage_q [DEPTH];
    logic [N-1:0] stage_d [DEPTH];
    logic         inc;

    assign inc = en && (rot == MODE_SHIFT);

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = (rot == MODE_ROT) ? stage_q[DEPTH-1] : d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    asr_fill_ctr #(
        .DEPTH (DEPTH)
    ) u_fill_ctr (
        .clk   (clk),
        .clr   (clr),
        .flush (flush),
        .inc   (inc),
        .fill  (fill),
        .full  (full)
    );

    logic [AW-1:0] tap_add [2];
    logic [N-1:0]  tap_q   [2];
    logic          tap_vld [2];

    assign tap_add[0] = add_a;
    assign tap_add[1] = add_b;

    // Addresses past DEPTH-1 exist only for non-power-of-2 depths and read as empty.
    for (genvar g = 0; g < 2; g++) begin : g_tap
        logic in_rng;
        assign in_rng     = (int'(tap_add[g]) < DEPTH);
        assign tap_q[g]   = in_rng ? stage_q[tap_add[g]] : '0;
        assign tap_vld[g] = in_rng && ({1'b0, tap_add[g]} < fill);
    end

    assign q_a   = tap_q[0];
    assign q_b   = tap_q[1];
    assign vld_a = tap_vld[0];
    assign vld_b = tap_vld[1];

endmodule

// File: tb/tb_asr_tap.sv
// Bench for asr_tap: directed vector table on DEPTH=8, odd-depth corners on DEPTH=5, random vs queue model.
module tb_asr_tap;

    logic       clk;
    logic       clr;
    logic       en;
    logic       rot;
    logic       flush;
    logic [3:0] d;
    logic [2:0] add_a;
    logic [2:0] add_b;

    logic [3:0] q_a8, q_b8, q_a5, q_b5;
    logic       vld_a8, vld_b8, vld_a5, vld_b5;
    logic [3:0] fill8, fill5;
    logic       full8, full5;

    asr_tap #(.N(4), .DEPTH(8)) dut8 (
        .clk(clk), .clr(clr), .en(en), .rot(rot), .flush(flush), .d(d),
        .add_a(add_a), .add_b(add_b), .q_a(q_a8), .q_b(q_b8),
        .vld_a(vld_a8), .vld_b(vld_b8), .fill(fill8), .full(full8)
    );

    asr_tap #(.N(4), .DEPTH(5)) dut5 (
        .clk(clk), .clr(clr), .en(en), .rot(rot), .flush(flush), .d(d),
        .add_a(add_a), .add_b(add_b), .q_a(q_a5), .q_b(q_b5),
        .vld_a(vld_a5), .vld_b(vld_b5), .fill(fill5), .full(full5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    endtask

    // Reference model: index 0 is the newest entry of each delay line.
    int m [2][$];
    int f [2];
    int dep [2] = '{8, 5};

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m[j] = {};
            for (int i = 0; i < dep[j]; i++) m[j].push_back(0);
            f[j] = 0;
        end
    endtask

    task automatic model_edge(input bit e, input bit r, input bit fl, input int dv);
        for (int j = 0; j < 2; j++) begin
            if (e && !r) begin
                m[j].push_front(dv);
                void'(m[j].pop_back());
            end else if (e && r) begin
                m[j].push_front(m[j].pop_back());
            end
            if (fl) f[j] = (e && !r) ? 1 : 0;
            else if (e && !r && f[j] < dep[j]) f[j] = f[j] + 1;
        end
    endtask

    function automatic int exp_q(input int j, input int a);
        return (a < dep[j]) ? m[j][a] : 0;
    endfunction

    function automatic int exp_v(input int j, input int a);
        return (a < f[j] && a < dep[j]) ? 1 : 0;
    endfunction

    task automatic chk_model(input string tag);
        int a, b;
        a = int'(add_a);
        b = int'(add_b);
        chk({tag, " d8 q_a"}, int'(q_a8), exp_q(0, a));
        chk({tag, " d8 q_b"}, int'(q_b8), exp_q(0, b));
        chk({tag, " d8 vld_a"}, int'(vld_a8), exp_v(0, a));
        chk({tag, " d8 vld_b"}, int'(vld_b8), exp_v(0, b));
        chk({tag, " d8 fill"}, int'(fill8), f[0]);
        chk({tag, " d8 full"}, int'(full8), (f[0] == 8) ? 1 : 0);
        chk({tag, " d5 q_a"}, int'(q_a5), exp_q(1, a));
        chk({tag, " d5 q_b"}, int'(q_b5), exp_q(1, b));
        chk({tag, " d5 vld_a"}, int'(vld_a5), exp_v(1, a));
        chk({tag, " d5 vld_b"}, int'(vld_b5), exp_v(1, b));
        chk({tag, " d5 fill"}, int'(fill5), f[1]);
        chk({tag, " d5 full"}, int'(full5), (f[1] == 5) ? 1 : 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " d8 q_a"}, int'(q_a8), 0);
        chk({tag, " d8 q_b"}, int'(q_b8), 0);
        chk({tag, " d8 vld"}, int'({vld_a8, vld_b8}), 0);
        chk({tag, " d8 fill"}, int'(fill8), 0);
        chk({tag, " d8 full"}, int'(full8), 0);
        chk({tag, " d5 q_a"}, int'(q_a5), 0);
        chk({tag, " d5 q_b"}, int'(q_b5), 0);
        chk({tag, " d5 vld"}, int'({vld_a5, vld_b5}), 0);
        chk({tag, " d5 fill"}, int'(fill5), 0);
        chk({tag, " d5 full"}, int'(full5), 0);
    endtask

    task automatic step(input bit e, input bit r, input bit fl, input logic [3:0] dv);
        en = e; rot = r; flush = fl; d = dv;
        @(posedge clk);
        model_edge(e, r, fl, int'(dv));
        #1;
    endtask

    typedef struct {
        bit         en, rot, fl;
        logic [3:0] d;
        logic [2:0] aa, ab;
        int         qa, qb, va, vb, fill;
    } vec_t;

    function automatic vec_t mk(input bit e, input bit r, input bit fl, input int dv,
                                input int aa, input int ab, input int qa, input int qb,
                                input int va, input int vb, input int fl_cnt);
        vec_t v;
        v.en = e; v.rot = r; v.fl = fl; v.d = 4'(dv); v.aa = 3'(aa); v.ab = 3'(ab);
        v.qa = qa; v.qb = qb; v.va = va; v.vb = vb; v.fill = fl_cnt;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int s7 [10] = '{0, 0, 0, 3, 2, 4, 5, 1, 2, 3};
        int rot0 [8] = '{3, 4, 5, 6, 7, 8, 9, 10};
        int rot7 [8] = '{10, 5, 6, 7, 8, 9, 10, 3};

        // shift/delay
        tbl.push_back(mk(1, 0, 0, 3, 0, 3, 3, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2, 0, 3, 2, 0, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 4, 0, 3, 4, 0, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 5, 0, 3, 5, 3, 1, 1, 4));
        tbl.push_back(mk(0, 0, 0, 9, 4, 3, 0, 3, 0, 1, 4));
        // saturation: stage 7 ends holding 3
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(1, 0, 0, k, 0, 7, k, s7[k-1], 1, (k >= 4) ? 1 : 0,
                             (4 + k > 8) ? 8 : 4 + k));
        // rotate: first edge checked at taps 0/1, then eight in total
        tbl.push_back(mk(1, 1, 0, 15, 0, 1, 3, 10, 1, 1, 8));
        for (int r = 2; r <= 8; r++)
            tbl.push_back(mk(1, 1, 0, 15, 0, 7, rot0[r-1], rot7[r-1], 1, 1, 8));
        // flush with shift, flush alone, flush with rotate, then shift
        tbl.push_back(mk(1, 0, 1, 7, 0, 1, 7, 10, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 2, 0, 1, 7, 10, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 2, 0, 1, 4, 7, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 9, 0, 1, 9, 4, 1, 0, 1));

        clr = 1'b1; en = 0; rot = 0; flush = 0; d = 0; add_a = 0; add_b = 0;
        model_reset();
        #11;
        chk_zero("reset_init");
        clr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].rot, tbl[i].fl, tbl[i].d);
            add_a = tbl[i].aa; add_b = tbl[i].ab;
            #1;
            chk($sformatf("vec%0d q_a", i), int'(q_a8), tbl[i].qa);
            chk($sformatf("vec%0d q_b", i), int'(q_b8), tbl[i].qb);
            chk($sformatf("vec%0d vld_a", i), int'(vld_a8), tbl[i].va);
            chk($sformatf("vec%0d vld_b", i), int'(vld_b8), tbl[i].vb);
            chk($sformatf("vec%0d fill", i), int'(fill8), tbl[i].fill);
            chk($sformatf("vec%0d full", i), int'(full8), (tbl[i].fill == 8) ? 1 : 0);
            chk_model($sformatf("vec%0d", i));
        end

        // asynchronous clear between edges, then held across an enabled edge
        step(1, 0, 0, 4'd6);
        step(1, 0, 0, 4'd5);
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        chk_zero("clr_mid");
        en = 1; rot = 0; d = 4'hF;
        @(posedge clk);
        #1;
        chk_zero("clr_held");
        #2;
        clr = 1'b0;

        // odd depth: out-of-range addresses, then hold
        for (int k = 1; k <= 6; k++) step(1, 0, 0, 4'(k));
        add_a = 3'd5; add_b = 3'd7;
        #1;
        chk("odd q_a", int'(q_a5), 0);
        chk("odd q_b", int'(q_b5), 0);
        chk("odd vld_a", int'(vld_a5), 0);
        chk("odd vld_b", int'(vld_b5), 0);
        chk("odd fill", int'(fill5), 5);
        chk("odd full", int'(full5), 1);
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 4'(c + 9));
            add_a = 3'd4; add_b = 3'd0;
            #1;
            chk($sformatf("odd hold%0d q_a", c), int'(q_a5), 2);
            chk($sformatf("odd hold%0d q_b", c), int'(q_b5), 6);
            chk($sformatf("odd hold%0d fill", c), int'(fill5), 5);
            chk_model($sformatf("odd hold%0d", c));
        end
        for (int k = 0; k < 3; k++) step(1, 0, 0, 4'(k));
        #1;
        chk("sat d8 fill", int'(fill8), 8);
        chk("sat d8 full", int'(full8), 1);

        // random traffic against the queue model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                clr = 1'b1;
                model_reset();
                #1;
                chk_zero($sformatf("rnd%0d clr", c));
                #1;
                clr = 1'b0;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, 4'($urandom));
            add_a = 3'($urandom);
            add_b = ($urandom_range(0, 7) == 0) ? add_a : 3'($urandom);
            #1;
            chk_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
